tdc_hit_readout: RTL

Receiving end of the TDC controller's encoded-data path: samples encoded TOA/TOT/Cal codes on each EncdataWrtClk strobe, tags them with ResetFlag, and buffers hit words in a small FIFO. Sits between the per-pixel TDC (controller + encoder) and the pixel readout/serializer. Drains words over a valid/ready handshake. Runs entirely in the clk40 domain; the strobe is treated as asynchronous and synchronized internally.

---
 rtl/tdc_pkg.sv | 23 ++
 rtl/tdc_readout_fifo.sv | 57 +++++
 rtl/tdc_hit_readout.sv | 122 ++++++++++++
 3 files changed

// File: rtl/tdc_pkg.sv
// Shared types and constants for the TDC hit readout: default code widths,
// hit-word layout and FSM state encoding.
package tdc_pkg;

  localparam int TOA_W_DEF = 10;
  localparam int TOT_W_DEF = 9;
  localparam int CAL_W_DEF = 10;

  localparam int HIT_W = 1 + CAL_W_DEF + TOT_W_DEF + TOA_W_DEF;

  // Field offsets within the hit word {resetFlag, cal, tot, toa}
  localparam int TOA_LSB = 0;
  localparam int TOT_LSB = TOA_W_DEF;
  localparam int CAL_LSB = TOA_W_DEF + TOT_W_DEF;
  localparam int RF_BIT  = HIT_W - 1;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    WRITE   = 2'd2
  } tdc_state_e;

endpackage

// File: rtl/tdc_readout_fifo.sv
// Synchronous show-ahead FIFO: head word is presented on o_data whenever the
// FIFO is non-empty. Push while full is accepted only alongside a pop.
module tdc_readout_fifo #(
  parameter int W     = 30,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_push,
  input  logic [W-1:0]             i_data,
  input  logic                     i_pop,
  output logic [W-1:0]             o_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  r_mem [DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [AW:0]   r_count;
  logic          w_do_pop;
  logic          w_do_push;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == (AW+1)'(DEPTH));
  assign w_do_pop  = i_pop & ~o_empty;
  assign w_do_push = i_push & (~o_full | w_do_pop);
  assign o_count   = r_count;
  assign o_data    = o_empty ? '0 : r_mem[r_rd_ptr];

  // Pointers are exactly AW bits wide, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; o_data is masked to zero while
  // empty, so stale contents can never be observed after a reset.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= i_data;
  end

endmodule

// File: rtl/tdc_hit_readout.sv
// TDC encoded-data receiver: synchronizes EncdataWrtClk, captures codes into a
// tagged hit word and buffers it for readout. Optional TOA window filter
// enabled by defining TDC_HIT_WINDOW_EN.
module tdc_hit_readout
  import tdc_pkg::*;
#(
  parameter int TOA_W = TOA_W_DEF,
  parameter int TOT_W = TOT_W_DEF,
  parameter int CAL_W = CAL_W_DEF,
  parameter int DEPTH = 8,
  parameter int OVF_W = 8
) (
  input  logic                           clk40,
  input  logic                           resetn,
  input  logic                           enable,
  input  logic                           encStrobe,
  input  logic                           resetFlag,
  input  logic [TOA_W-1:0]               toaCode,
  input  logic [TOT_W-1:0]               totCode,
  input  logic [CAL_W-1:0]               calCode,
  input  logic [TOA_W-1:0]               toaLow,
  input  logic [TOA_W-1:0]               toaHigh,
  output logic [CAL_W+TOT_W+TOA_W:0]     dout,
  output logic                           doutValid,
  input  logic                           doutReady,
  output logic [$clog2(DEPTH):0]         fifoCount,
  output logic [OVF_W-1:0]               ovfCount,
  output logic [15:0]                    hitCount
);

  localparam int WORD_W = 1 + CAL_W + TOT_W + TOA_W;

  logic              r_s1, r_s2, r_s3, r_rise;
  tdc_state_e        r_state;
  logic [WORD_W-1:0] r_word;
  logic [OVF_W-1:0]  r_ovf;
  logic [15:0]       r_hits;

  logic w_in_window;
  logic w_push_req;
  logic w_pop;
  logic w_drop;
  logic w_push_acc;
  logic w_full;
  logic w_empty;

  // Strobe is asynchronous: two-flop synchronizer, then edge detect on s2/s3.
  always_ff @(posedge clk40) begin
    if (!resetn) begin
      r_s1   <= 1'b0;
      r_s2   <= 1'b0;
      r_s3   <= 1'b0;
      r_rise <= 1'b0;
    end else begin
      r_s1   <= encStrobe;
      r_s2   <= r_s1;
      r_s3   <= r_s2;
      r_rise <= r_s2 & ~r_s3;
    end
  end

  // Rises are only honoured in IDLE, so a strobe during CAPTURE/WRITE is lost.
  always_ff @(posedge clk40) begin
    if (!resetn) begin
      r_state <= IDLE;
      r_word  <= '0;
    end else begin
      case (r_state)
        IDLE:    if (r_rise && enable) r_state <= CAPTURE;
        CAPTURE: begin
          r_word  <= {resetFlag, calCode, totCode, toaCode};
          r_state <= WRITE;
        end
        WRITE:   r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef TDC_HIT_WINDOW_EN
  assign w_in_window = (r_word[TOA_W-1:0] >= toaLow) && (r_word[TOA_W-1:0] <= toaHigh);
`else
  logic w_unused_window;
  assign w_unused_window = ^{toaLow, toaHigh};
  assign w_in_window     = 1'b1;
`endif

  assign w_push_req = (r_state == WRITE) && w_in_window;
  assign w_pop      = doutReady & ~w_empty;
  assign w_drop     = w_push_req & w_full & ~w_pop;
  assign w_push_acc = w_push_req & ~w_drop;

  tdc_readout_fifo #(
    .W     (WORD_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk40),
    .rst_n   (resetn),
    .i_push  (w_push_req),
    .i_data  (r_word),
    .i_pop   (doutReady),
    .o_data  (dout),
    .o_count (fifoCount),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  always_ff @(posedge clk40) begin
    if (!resetn) begin
      r_ovf  <= '0;
      r_hits <= '0;
    end else begin
      if (w_push_acc)                r_hits <= r_hits + 16'd1;
      if (w_drop && (r_ovf != '1))   r_ovf  <= r_ovf + 1'b1;
    end
  end

  assign doutValid = ~w_empty;
  assign ovfCount  = r_ovf;
  assign hitCount  = r_hits;

endmodule
